// File: rtl/pipe_pkg.sv
// Shared widths, ALU op encodings and the control bundle used by the
// pipeline registers of the 5-stage datapath.
package pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               branch;
    } ctrl_t;

    // A NOP never writes a register or memory, so its control is all zero.
    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Width-parameterised pipeline field register: async reset, hold enable,
// synchronous clear. Clear takes priority over hold so a flush can squash a stalled stage.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, bubble and flush handling plus a
// saturating count of inserted NOPs for performance debug.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = pipe_pkg::DATA_W,
    parameter int REG_AW  = pipe_pkg::REG_AW,
    parameter int ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               bubble,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_rs1_data,
    input  logic [DATA_W-1:0]  id_rs2_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_branch,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs1_data,
    output logic [DATA_W-1:0]  ex_rs2_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic [CNT_W-1:0]   nop_count
);

    logic load_nop;
    logic hold;

    // Flush beats stall; stall beats bubble.
    assign load_nop = flush | (bubble & ~stall);
    assign hold     = stall & ~flush;

    logic [4*DATA_W-1:0] data_q;
    logic [3*REG_AW-1:0] idx_q;
    ctrl_t               ctrl_d;
    ctrl_t               ctrl_q;

    assign ctrl_d = '{alu_op:     id_alu_op,
                      alu_src:    id_alu_src,
                      mem_read:   id_mem_read,
                      mem_write:  id_mem_write,
                      reg_write:  id_reg_write,
                      mem_to_reg: id_mem_to_reg,
                      branch:     id_branch};

    pipe_field_reg #(.W(4*DATA_W)) u_data (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (load_nop),
        .d     ({id_pc, id_rs1_data, id_rs2_data, id_imm}),
        .q     (data_q)
    );

    pipe_field_reg #(.W(3*REG_AW)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (load_nop),
        .d     ({id_rs1, id_rs2, id_rd}),
        .q     (idx_q)
    );

    pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (load_nop),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    pipe_field_reg #(.W(1)) u_valid (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .clear (load_nop),
        .d     (id_valid),
        .q     (ex_valid)
    );

    assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} = data_q;
    assign {ex_rs1, ex_rs2, ex_rd}                   = idx_q;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nop_count <= '0;
        end else if (load_nop && (nop_count != {CNT_W{1'b1}})) begin
            nop_count <= nop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a driver pushes the expected EX view
// into a queue each cycle, an independent monitor pops and compares.
module tb_id_ex_pipe_reg;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, bubble = 1'b0, flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]  id_alu_op = '0;
    logic        id_alu_src = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_to_reg = 1'b0, id_branch = 1'b0;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic [CNT_W-1:0] nop_count;

    id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .nop_count(nop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu_op;
        logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    obs_t model = '0;
    int   model_cnt = 0;
    int   tests = 0;
    int   failed = 0;

    function automatic obs_t get_obs();
        obs_t o;
        o.valid = ex_valid;   o.pc = ex_pc;   o.rs1_data = ex_rs1_data;
        o.rs2_data = ex_rs2_data;   o.imm = ex_imm;
        o.rs1 = ex_rs1;   o.rs2 = ex_rs2;   o.rd = ex_rd;   o.alu_op = ex_alu_op;
        o.alu_src = ex_alu_src;   o.mem_read = ex_mem_read;   o.mem_write = ex_mem_write;
        o.reg_write = ex_reg_write;   o.mem_to_reg = ex_mem_to_reg;   o.branch = ex_branch;
        o.cnt = nop_count;
        return o;
    endfunction

    // Reference: flush or unstalled bubble gives an empty slot and one more
    // counted NOP (capped); a plain stall keeps the slot; otherwise ID moves in.
    task automatic issue();
        obs_t nxt;
        nxt = model;
        if (flush || (bubble && !stall)) begin
            nxt = '0;
            if (model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
        end else if (!stall) begin
            nxt.valid = id_valid;   nxt.pc = id_pc;   nxt.rs1_data = id_rs1_data;
            nxt.rs2_data = id_rs2_data;   nxt.imm = id_imm;
            nxt.rs1 = id_rs1;   nxt.rs2 = id_rs2;   nxt.rd = id_rd;   nxt.alu_op = id_alu_op;
            nxt.alu_src = id_alu_src;   nxt.mem_read = id_mem_read;
            nxt.mem_write = id_mem_write;   nxt.reg_write = id_reg_write;
            nxt.mem_to_reg = id_mem_to_reg;   nxt.branch = id_branch;
        end
        nxt.cnt = CNT_W'(model_cnt);
        model = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_id();
        id_valid = 1'($urandom);   id_pc = $urandom;   id_rs1_data = $urandom;
        id_rs2_data = $urandom;   id_imm = $urandom;
        id_rs1 = 5'($urandom);   id_rs2 = 5'($urandom);   id_rd = 5'($urandom);
        id_alu_op = 4'($urandom);   id_alu_src = 1'($urandom);   id_mem_read = 1'($urandom);
        id_mem_write = 1'($urandom);   id_reg_write = 1'($urandom);
        id_mem_to_reg = 1'($urandom);   id_branch = 1'($urandom);
    endtask

    task automatic check_all_zero(input string name);
        obs_t a;
        a = get_obs();
        tests++;
        if (a !== '0) begin
            failed++;
            $display("FAIL %s: outputs got %h want 0", name, a);
        end
    endtask

    task automatic do_reset_model();
        model = '0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    // Monitor: every post-edge sample with a pending expectation is compared.
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = get_obs();
            tests++;
            if (a !== e) begin
                failed++;
                $display("FAIL ex_view @%0t: got %h want %h", $time, a, e);
            end
        end
    end

    initial begin
        #3;
        check_all_zero("reset_initial");
        @(negedge clk);
        rst = 1'b0;

        id_valid = 1'b1;   id_pc = 32'h100;
        issue();

        id_rs2_data = 32'hDEADBEEF;   id_imm = 32'h10;   id_alu_src = 1'b1;
        id_reg_write = 1'b1;   id_rd = 5'd5;   id_valid = 1'b1;
        issue();

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            issue();
        end
        stall = 1'b0;
        rand_id();
        issue();

        bubble = 1'b1;
        issue();
        bubble = 1'b0;   flush = 1'b1;   stall = 1'b1;
        issue();
        flush = 1'b0;   stall = 1'b0;

        flush = 1'b1;   bubble = 1'b1;
        issue();
        flush = 1'b0;   stall = 1'b1;
        issue();
        stall = 1'b0;   bubble = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rand_id();
            id_valid = 1'b1;   id_pc = 32'h1000 | $urandom;
            issue();
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async_mid_cycle");
        do_reset_model();
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b1;   id_pc = 32'h100;
        issue();

        bubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_id();
            issue();
        end
        bubble = 1'b0;

        for (int i = 0; i < 300; i++) begin
            rand_id();
            flush  = ($urandom_range(0, 9) == 0);
            stall  = ($urandom_range(0, 4) == 0);
            bubble = ($urandom_range(0, 6) == 0);
            issue();
        end
        flush = 1'b0;   stall = 1'b0;   bubble = 1'b0;

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: pending got %0d want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
